// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: bus widths and FSM state encodings.
package prog_loader_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [2:0] S_CNT_LO = 3'd0;
    localparam logic [2:0] S_CNT_HI = 3'd1;
    localparam logic [2:0] S_DAT_LO = 3'd2;
    localparam logic [2:0] S_DAT_HI = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    // States in which the loader still expects stream bytes.
    function automatic logic state_accepts(input logic [2:0] s);
        return (s == S_CNT_LO) || (s == S_CNT_HI) || (s == S_DAT_LO) ||
               (s == S_DAT_HI) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, out-of-band memory write port and status of the program loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic              load_start;
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] oob_write_addr;
    logic [DATA_W-1:0] oob_write_data;
    logic              oob_mem_wen;
    logic              proc_rst;
    logic              done;
    logic              error;

    modport master (
        input  load_start, rx_valid, rx_data,
        output rx_ready, oob_write_addr, oob_write_data, oob_mem_wen,
               proc_rst, done, error
    );

    modport slave (
        output load_start, rx_valid, rx_data,
        input  rx_ready, oob_write_addr, oob_write_data, oob_mem_wen,
               proc_rst, done, error
    );

endinterface

// File: rtl/prog_loader.sv
// Loads a little-endian word stream (count header, then words) into program memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte over the whole stream.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0]       MAX_WORDS = 16'd4096
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.master bus
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_AFTER_DATA = S_CSUM;
`else
    localparam logic [2:0] S_AFTER_DATA = S_FIN;
`endif

    logic [2:0]        state_q, state_d;
    logic [15:0]       index_q, index_d;
    logic [15:0]       count_q, count_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    logic        rx_ready;
    logic        xfer;
    logic [15:0] hdr_count;
    logic        last_word;

    assign rx_ready  = state_accepts(state_q) && !bus.load_start;
    assign xfer      = bus.rx_valid && rx_ready;
    assign hdr_count = {bus.rx_data, lo_q};
    assign last_word = (index_q == count_q - 16'd1);

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        lo_d    = lo_q;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (bus.load_start) begin
            state_d = S_CNT_LO;
            index_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else begin
            if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d = csum_q + bus.rx_data;
`endif
                case (state_q)
                    S_CNT_LO: begin
                        lo_d    = bus.rx_data;
                        state_d = S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        count_d = hdr_count;
                        if (hdr_count == 16'd0)
                            state_d = S_AFTER_DATA;
                        else if (hdr_count > MAX_WORDS)
                            state_d = S_ERR;
                        else
                            state_d = S_DAT_LO;
                    end
                    S_DAT_LO: begin
                        lo_d    = bus.rx_data;
                        state_d = S_DAT_HI;
                    end
                    S_DAT_HI: begin
                        // Write is registered: strobe, address and data all appear the next cycle.
                        wen_d   = 1'b1;
                        addr_d  = BASE_ADDR + index_q;
                        data_d  = {bus.rx_data, lo_q};
                        index_d = index_q + 16'd1;
                        state_d = last_word ? S_AFTER_DATA : S_DAT_LO;
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        state_d = (bus.rx_data == csum_q) ? S_FIN : S_ERR;
                    end
`endif
                    default: ;
                endcase
            end
            if (state_q == S_FIN)
                state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CNT_LO;
            index_q <= '0;
            count_q <= '0;
            lo_q    <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
            lo_q    <= lo_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.rx_ready       = rx_ready;
    assign bus.oob_mem_wen    = wen_q;
    assign bus.oob_write_addr = addr_q;
    assign bus.oob_write_data = data_q;
    assign bus.done           = (state_q == S_DONE);
    assign bus.error          = (state_q == S_ERR);
    assign bus.proc_rst       = (state_q != S_DONE);

endmodule
